cpu_bus_seq: RTL and testbench
==============================

// Module: cpu_bus_seq
// PURPOSE
// - M-cycle bus sequencer between CPU control (bus_opcode_t requests) and the memory bus.
// - Expands each request into T_PER_M T-cycles with address/strobe phasing and memory-ready wait states.
// - Captures read data and tags fetches (IF / IF_CB) for the decoder.
// - Parametrised successor of the fixed 4-T, no-wait bus model: adds width params, wait states,
//   timeout with open-bus data, and back-to-back acceptance.
// PARAMETERS
// ADDR_W        16  memory address width
// DATA_W        8   memory data width
// T_PER_M       4   T-cycles per M-cycle (>=3)
// WAIT_TIMEOUT  15  max wait-state cycles before abort (>=1)
// CNT_W         16  width of completed-M-cycle counter
// PORTS
// clk           in   1        system clock, rising edge
// rst_n         in   1        async active-low reset
// req_valid     in   1        request present
// req_ready     out  1        sequencer accepts request this cycle
// req_op        in   3        bus_opcode_t: IDLE, IF, WRITE, READ, IF_CB
// req_addr      in   ADDR_W   request address
// req_wdata     in   DATA_W   write data (WRITE only)
// rsp_valid     out  1        one-cycle pulse: M-cycle complete
// rsp_rdata     out  DATA_W   captured read data, held until next capture
// rsp_is_fetch  out  1        completed op was IF or IF_CB
// rsp_is_cb     out  1        completed op was IF_CB
// rsp_timeout   out  1        completed op aborted by wait timeout
// mem_addr      out  ADDR_W   bus address
// mem_wdata     out  DATA_W   bus write data
// mem_rd        out  1        read strobe
// mem_wr        out  1        write strobe
// mem_ready     in   1        memory ready; low stretches access
// mem_rdata     in   DATA_W   bus read data
// tcycle        out  $clog2(T_PER_M)  current T index (0 when idle)
// busy          out  1        M-cycle in progress
// mcycle_cnt    out  CNT_W    completed M-cycles, wraps to 0
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; all outputs 0 except req_ready=1;
//   in-flight op dropped with no rsp_valid.
// - States: IDLE, RUN (tcycle advancing), WAIT (stretch), back to IDLE or RUN.
// - req_ready = (state==IDLE) | (state==RUN & tcycle==T_PER_M-1); accept = req_valid & req_ready.
//   Back-to-back requests run with no bubble.
// - On accept edge: latch op/addr/wdata; enter RUN with tcycle=0.
//   mem_addr/mem_wdata driven from tcycle 0 and held through the op.
// - Strobes: mem_rd (IF/READ/IF_CB) or mem_wr (WRITE) high for tcycle 1..T_PER_M-2 and in WAIT.
//   Both are low at tcycle 0 and T_PER_M-1. Never both high.
// - At tcycle T_PER_M-2:
//   - mem_ready=1: read ops capture mem_rdata into rsp_rdata at that edge; advance.
//   - mem_ready=0: enter WAIT; tcycle frozen; wait counter starts at 1.
// - WAIT:
//   - mem_ready=1: capture (reads); go to tcycle T_PER_M-1.
//   - wait counter reaches WAIT_TIMEOUT: abort to tcycle T_PER_M-1; reads load all-ones
//     (open bus); rsp_timeout=1 for that response.
// - tcycle T_PER_M-1: strobes low; rsp_valid=1 for one cycle with rsp_is_fetch, rsp_is_cb,
//   rsp_timeout; mcycle_cnt increments (wraps from 2^CNT_W-1 to 0).
//   - accept: next op starts at tcycle 0; else go IDLE.
// - IDLE op (and encodings 5-7): internal M-cycle. No strobes; mem_ready ignored.
//   rsp_valid at T_PER_M-1; rsp_rdata unchanged.
// - Writes never modify rsp_rdata; a write timeout still completes with rsp_timeout=1.
// - busy=1 in RUN and WAIT. Nominal latency: accept edge -> rsp_valid T_PER_M cycles later,
//   plus wait cycles.
// - Request inputs are ignored while req_ready=0.
// TESTING
// - READ 0xC000, mem_ready=1, mem_rdata=0x5A -> mem_rd high T1..T2; rsp_valid 4 clk after
//   accept; rsp_rdata=0x5A; flags 0.
// - IF_CB 0x0150, then WRITE 0xFF40 data 0x91 back-to-back -> rsp_is_fetch=1, rsp_is_cb=1;
//   write strobes start next clk with no bubble; mem_wdata=0x91; rsp_rdata unchanged.
// - READ with mem_ready low for 3 clk at T2 -> 3 WAIT cycles, tcycle held at 2; rsp_valid 7 clk
//   after accept; data captured on ready edge.
// - READ with mem_ready stuck low, WAIT_TIMEOUT=15 -> abort after 15 wait cycles;
//   rsp_rdata=0xFF; rsp_timeout=1; next op normal.
// - rst_n pulled low at tcycle 2 of a WRITE -> strobes drop immediately; no rsp_valid;
//   mcycle_cnt=0; req_ready=1 after release.
// - CNT_W=4, 17 IDLE ops -> no strobes; 17 rsp_valid pulses; mcycle_cnt wraps to 1.

Source files
------------

// File: rtl/cpu_bus_seq.sv
// M-cycle bus sequencer: expands CPU bus requests into T-cycle strobe phasing with
// memory wait states, wait timeout (open-bus data) and back-to-back request acceptance.
module cpu_bus_seq #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned T_PER_M      = 4,
  parameter int unsigned WAIT_TIMEOUT = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [2:0]                 req_op_i,
  input  logic [ADDR_W-1:0]          req_addr_i,
  input  logic [DATA_W-1:0]          req_wdata_i,
  output logic                       rsp_valid_o,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_is_fetch_o,
  output logic                       rsp_is_cb_o,
  output logic                       rsp_timeout_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]          mem_wdata_o,
  output logic                       mem_rd_o,
  output logic                       mem_wr_o,
  input  logic                       mem_ready_i,
  input  logic [DATA_W-1:0]          mem_rdata_i,
  output logic [$clog2(T_PER_M)-1:0] tcycle_o,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           mcycle_cnt_o
);

  localparam int unsigned TW = $clog2(T_PER_M);
  localparam int unsigned WW = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [TW-1:0] TLast   = TW'(T_PER_M - 1);
  localparam logic [TW-1:0] TSample = TW'(T_PER_M - 2);
  localparam logic [WW-1:0] WaitMax = WW'(WAIT_TIMEOUT);

  localparam logic [2:0] OpIdle  = 3'd0;
  localparam logic [2:0] OpIf    = 3'd1;
  localparam logic [2:0] OpWrite = 3'd2;
  localparam logic [2:0] OpRead  = 3'd3;
  localparam logic [2:0] OpIfCb  = 3'd4;

  typedef enum logic [1:0] {StIdle, StRun, StWait} state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       tcycle_q, tcycle_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    mcycle_cnt_q, mcycle_cnt_d;

  logic op_is_read, op_is_write, op_is_mem, at_last, accept;

  assign op_is_read  = (op_q == OpIf) || (op_q == OpRead) || (op_q == OpIfCb);
  assign op_is_write = (op_q == OpWrite);
  assign op_is_mem   = op_is_read || op_is_write;
  assign at_last     = (state_q == StRun) && (tcycle_q == TLast);
  assign accept      = req_valid_i && req_ready_o;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      tcycle_q     <= '0;
      op_q         <= OpIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      mcycle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      tcycle_q     <= tcycle_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
      mcycle_cnt_q <= mcycle_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    tcycle_d     = tcycle_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    mcycle_cnt_d = mcycle_cnt_q;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        if (tcycle_q == TLast) begin
          mcycle_cnt_d = mcycle_cnt_q + 1'b1;
          state_d      = StIdle;
          tcycle_d     = '0;
        end else if ((tcycle_q == TSample) && op_is_mem) begin
          if (mem_ready_i) begin
            if (op_is_read) rdata_d = mem_rdata_i;
            tcycle_d = TLast;
          end else begin
            state_d    = StWait;
            wait_cnt_d = WW'(1);
          end
        end else begin
          tcycle_d = tcycle_q + 1'b1;
        end
      end
      StWait: begin
        if (mem_ready_i) begin
          if (op_is_read) rdata_d = mem_rdata_i;
          state_d  = StRun;
          tcycle_d = TLast;
        end else if (wait_cnt_q == WaitMax) begin
          // Abort: nothing drives the bus, so reads see open-bus all-ones.
          if (op_is_read) rdata_d = '1;
          timeout_d = 1'b1;
          state_d   = StRun;
          tcycle_d  = TLast;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        tcycle_d = '0;
      end
    endcase

    // A new request overrides the return to idle, giving back-to-back M-cycles.
    if (accept) begin
      state_d    = StRun;
      tcycle_d   = '0;
      op_d       = req_op_i;
      addr_d     = req_addr_i;
      wdata_d    = req_wdata_i;
      wait_cnt_d = '0;
      timeout_d  = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    logic strobe_phase;
    strobe_phase   = ((state_q == StRun) && (tcycle_q != '0) && (tcycle_q != TLast)) ||
                     (state_q == StWait);
    req_ready_o    = (state_q == StIdle) || at_last;
    busy_o         = (state_q == StRun) || (state_q == StWait);
    tcycle_o       = tcycle_q;
    mem_addr_o     = addr_q;
    mem_wdata_o    = wdata_q;
    mem_rd_o       = strobe_phase && op_is_read;
    mem_wr_o       = strobe_phase && op_is_write;
    rsp_valid_o    = at_last;
    rsp_rdata_o    = rdata_q;
    rsp_is_fetch_o = at_last && ((op_q == OpIf) || (op_q == OpIfCb));
    rsp_is_cb_o    = at_last && (op_q == OpIfCb);
    rsp_timeout_o  = at_last && timeout_q;
    mcycle_cnt_o   = mcycle_cnt_q;
  end

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Directed self-checking bench for cpu_bus_seq: reads, fetch/write back-to-back, wait states,
// timeouts, asynchronous reset mid-op and counter wrap with a 4-bit counter.
module tb_cpu_bus_seq;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned TPM = 4;
  localparam int unsigned WTO = 15;
  localparam int unsigned CW  = 4;

  localparam logic [2:0] OpIdle  = 3'd0;
  localparam logic [2:0] OpIf    = 3'd1;
  localparam logic [2:0] OpWrite = 3'd2;
  localparam logic [2:0] OpRead  = 3'd3;
  localparam logic [2:0] OpIfCb  = 3'd4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_is_fetch, rsp_is_cb, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rd, mem_wr, mem_ready;
  logic [1:0]    tcycle;
  logic          busy;
  logic [CW-1:0] mcycle_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_bus_seq #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .T_PER_M     (TPM),
    .WAIT_TIMEOUT(WTO),
    .CNT_W       (CW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_op_i      (req_op),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_is_fetch_o(rsp_is_fetch),
    .rsp_is_cb_o   (rsp_is_cb),
    .rsp_timeout_o (rsp_timeout),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rd_o      (mem_rd),
    .mem_wr_o      (mem_wr),
    .mem_ready_i   (mem_ready),
    .mem_rdata_i   (mem_rdata),
    .tcycle_o      (tcycle),
    .busy_o        (busy),
    .mcycle_cnt_o  (mcycle_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  // Garbage on the request lines must be ignored while req_valid is low.
  task automatic drop();
    req_valid = 1'b0;
    req_op    = OpWrite;
    req_addr  = 16'hDEAD;
    req_wdata = 8'hBD;
  endtask

  // Latency counts the accept edge as clock 1.
  task automatic run_to_rsp(input int max, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
      if (lat == 1) drop();
    end while (!rsp_valid && lat < max);
  endtask

  initial begin
    int lat;
    int pulses;
    int strobes;
    int steps;

    rst_n     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 8'h00;
    drop();
    #2;
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_strobes", {mem_rd, mem_wr}, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
    check_eq("rst_cnt", mcycle_cnt, 0);
    check_eq("rst_tcycle", tcycle, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // READ 0xC000, no waits
    mem_rdata = 8'h5A;
    issue(OpRead, 16'hC000, 8'h00);
    step();
    drop();
    check_eq("rd_t0_tcycle", tcycle, 0);
    check_eq("rd_t0_addr", mem_addr, 16'hC000);
    check_eq("rd_t0_rd", mem_rd, 0);
    check_eq("rd_t0_busy", busy, 1);
    check_eq("rd_t0_ready", req_ready, 0);
    step();
    check_eq("rd_t1_tcycle", tcycle, 1);
    check_eq("rd_t1_strobes", {mem_rd, mem_wr}, 2'b10);
    step();
    check_eq("rd_t2_strobes", {mem_rd, mem_wr}, 2'b10);
    check_eq("rd_t2_addr", mem_addr, 16'hC000);
    step();
    check_eq("rd_t3_tcycle", tcycle, 3);
    check_eq("rd_t3_strobes", {mem_rd, mem_wr}, 2'b00);
    check_eq("rd_t3_valid", rsp_valid, 1);
    check_eq("rd_t3_rdata", rsp_rdata, 8'h5A);
    check_eq("rd_t3_flags", {rsp_is_fetch, rsp_is_cb, rsp_timeout}, 0);
    check_eq("rd_t3_ready", req_ready, 1);
    step();
    check_eq("rd_end_valid", rsp_valid, 0);
    check_eq("rd_end_busy", busy, 0);
    check_eq("rd_end_tcycle", tcycle, 0);
    check_eq("rd_end_cnt", mcycle_cnt, 1);

    // IF_CB 0x0150 followed back-to-back by WRITE 0xFF40
    mem_rdata = 8'h3C;
    issue(OpIfCb, 16'h0150, 8'h00);
    run_to_rsp(10, lat);
    check_eq("cb_latency", lat, 4);
    check_eq("cb_flags", {rsp_valid, rsp_is_fetch, rsp_is_cb, rsp_timeout}, 4'b1110);
    check_eq("cb_rdata", rsp_rdata, 8'h3C);
    check_eq("cb_ready", req_ready, 1);
    issue(OpWrite, 16'hFF40, 8'h91);
    step();
    drop();
    mem_rdata = 8'hEE;
    check_eq("wr_t0_tcycle", tcycle, 0);
    check_eq("wr_t0_busy", busy, 1);
    check_eq("wr_t0_addr", mem_addr, 16'hFF40);
    check_eq("wr_t0_wdata", mem_wdata, 8'h91);
    check_eq("wr_t0_cnt", mcycle_cnt, 2);
    step();
    check_eq("wr_t1_strobes", {mem_rd, mem_wr}, 2'b01);
    step();
    check_eq("wr_t2_strobes", {mem_rd, mem_wr}, 2'b01);
    check_eq("wr_t2_wdata", mem_wdata, 8'h91);
    step();
    check_eq("wr_t3_flags", {rsp_valid, rsp_is_fetch, rsp_is_cb, rsp_timeout}, 4'b1000);
    check_eq("wr_t3_rdata", rsp_rdata, 8'h3C);
    step();
    check_eq("wr_end_cnt", mcycle_cnt, 3);

    // READ with three wait states
    mem_rdata = 8'h00;
    issue(OpRead, 16'h1234, 8'h00);
    step();
    drop();
    step();
    mem_ready = 1'b0;
    mem_rdata = 8'h11;
    step();
    check_eq("ws_t2_tcycle", tcycle, 2);
    for (int w = 1; w <= 3; w++) begin
      step();
      check_eq($sformatf("ws_w%0d_tcycle", w), tcycle, 2);
      check_eq($sformatf("ws_w%0d_rd", w), mem_rd, 1);
      check_eq($sformatf("ws_w%0d_valid", w), rsp_valid, 0);
    end
    mem_ready = 1'b1;
    mem_rdata = 8'hA7;
    lat = 6;
    do begin
      step();
      lat++;
    end while (!rsp_valid && lat < 20);
    check_eq("ws_latency", lat, 7);
    check_eq("ws_rdata", rsp_rdata, 8'hA7);
    check_eq("ws_timeout", rsp_timeout, 0);
    step();
    check_eq("ws_end_cnt", mcycle_cnt, 4);

    // READ with memory stuck not-ready: timeout, open-bus data
    mem_ready = 1'b0;
    mem_rdata = 8'h42;
    issue(OpRead, 16'h2000, 8'h00);
    run_to_rsp(40, lat);
    check_eq("to_latency", lat, 4 + WTO);
    check_eq("to_rdata", rsp_rdata, 8'hFF);
    check_eq("to_flags", {rsp_valid, rsp_is_fetch, rsp_timeout}, 3'b101);
    step();
    mem_ready = 1'b1;
    mem_rdata = 8'h66;
    issue(OpRead, 16'h2001, 8'h00);
    run_to_rsp(40, lat);
    check_eq("to_next_latency", lat, 4);
    check_eq("to_next_rdata", rsp_rdata, 8'h66);
    check_eq("to_next_timeout", rsp_timeout, 0);
    step();

    // WRITE timeout keeps read data
    mem_ready = 1'b0;
    issue(OpWrite, 16'h2002, 8'h77);
    run_to_rsp(40, lat);
    check_eq("wto_latency", lat, 4 + WTO);
    check_eq("wto_timeout", rsp_timeout, 1);
    check_eq("wto_rdata", rsp_rdata, 8'h66);
    step();
    check_eq("wto_cnt", mcycle_cnt, 7);

    // Asynchronous reset during T2 of a WRITE
    mem_ready = 1'b1;
    issue(OpWrite, 16'h3000, 8'h55);
    step();
    drop();
    step();
    step();
    check_eq("ar_t2_wr", mem_wr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_strobes", {mem_rd, mem_wr}, 0);
    check_eq("ar_busy", busy, 0);
    check_eq("ar_cnt", mcycle_cnt, 0);
    check_eq("ar_valid", rsp_valid, 0);
    check_eq("ar_ready", req_ready, 1);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq($sformatf("ar_post%0d_valid", c), rsp_valid, 0);
    end
    check_eq("ar_post_ready", req_ready, 1);
    check_eq("ar_post_cnt", mcycle_cnt, 0);

    // 17 back-to-back IDLE ops with mem_ready ignored; 4-bit counter wraps to 1
    mem_ready = 1'b0;
    pulses  = 0;
    strobes = 0;
    steps   = 0;
    issue(OpIdle, 16'h0000, 8'h00);
    while (pulses < 17 && steps < 200) begin
      step();
      steps++;
      if (mem_rd || mem_wr) strobes++;
      if (rsp_valid) begin
        pulses++;
        if (pulses == 17) drop();
      end
    end
    check_eq("idle_pulses", pulses, 17);
    check_eq("idle_steps", steps, 17 * TPM);
    check_eq("idle_strobes", strobes, 0);
    check_eq("idle_rdata", rsp_rdata, 0);
    step();
    check_eq("idle_cnt_wrap", mcycle_cnt, 1);
    check_eq("idle_end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
